pwm_multi_ch: RTL and testbench
===============================

PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 SHALL have parameter WIDTH, default 12, counter/period/compare width in bits (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent PWM outputs (>=1).
REQ-003 SHALL have parameter SELW, default $clog2(CHANNELS) (min 1), width of the channel select.
REQ-004 SHALL have port Clock  input  1  rising-edge clock, sole clock.
REQ-005 SHALL have port Rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port Clk_en  input  1  counter advance enable; counter and active registers hold when low.
REQ-007 SHALL have port Mode_wr  input  1  write strobe for shadow mode.
REQ-008 SHALL have port Mode_data  input  1  0 = up-count sawtooth, 1 = up-down symmetric.
REQ-009 SHALL have port Prd_wr  input  1  write strobe for shadow period.
REQ-010 SHALL have port Prd_data  input  WIDTH  period value.
REQ-011 SHALL have port Cmp_wr  input  1  write strobe for shadow compare of channel Cmp_sel.
REQ-012 SHALL have port Cmp_sel  input  SELW  channel index; writes with Cmp_sel>=CHANNELS ignored.
REQ-013 SHALL have port Cmp_data  input  WIDTH  compare value.
REQ-014 SHALL have port counter_out  output  WIDTH  current counter value (registered).
REQ-015 SHALL have port Ctr_0  output  1  high while counter_out==0.
REQ-016 SHALL have port Ctr_prd  output  1  high while counter_out==active period.
REQ-017 SHALL have port pwm_out  output  CHANNELS  per-channel PWM level.

Function
REQ-018 SHALL hold shadow mode/period/compare registers; each strobe writes its shadow at the Clock edge, independent of Clk_en.
REQ-019 SHALL copy all shadows into active registers at a "boundary edge": Clock edge with Clk_en=1 and counter_out==0.
REQ-020 SHALL, when a shadow write and a boundary edge coincide, transfer the pre-write shadow value; new value transfers at the next boundary.
REQ-021 SHALL, in active mode 0 on a Clk_en edge, go counter_out -> counter_out+1, or -> 0 when counter_out==active period (period PRD+1 counts).
REQ-022 SHALL, in active mode 1, keep a direction bit: count up to active period, then down to 0, then up (period 2*PRD counts); direction reverses on the edge where counter_out equals the endpoint.
REQ-023 SHALL keep counter_out at 0 when active period==0, either mode.
REQ-024 SHALL evaluate counter/direction steps with active values as they are after any same-edge boundary transfer.
REQ-025 SHALL set direction to up on every boundary edge.
REQ-026 SHALL drive pwm_out[i] = (counter_out < active compare[i]), combinational from registered state; compare 0 -> constant low; compare > active period -> constant high.
REQ-027 SHALL drive Ctr_0 and Ctr_prd combinationally from counter_out and active period; both high together when period==0.
REQ-028 SHALL use unsigned arithmetic throughout; counter never exceeds active period.

Reset
REQ-029 SHALL, on Clock edge with Rst=1, clear counter_out, direction (up), all shadow and active registers (mode 0, period 0, compares 0); Rst overrides Clk_en and all strobes.
REQ-030 SHALL, after reset, output counter_out=0, Ctr_0=1, Ctr_prd=1, pwm_out=0.
REQ-031 SHALL, on Rst mid-period, discard pending shadow writes and restart from count 0 on the next edge.

Verification
REQ-032 SHALL test: reset; write period 4, compare ch0=2, Clk_en=1, mode 0 -> counter 0,1,2,3,4,0...; pwm_out[0] high at counts 0,1; Ctr_prd at count 4.
REQ-033 SHALL test: mode 1, period 3, compare ch1=2 -> counter 0,1,2,3,2,1,0,1...; pwm_out[1] high at counts 0,1 both slopes.
REQ-034 SHALL test: mid-period write compare ch0 3->1 at count 2 -> pwm_out[0] keeps 3 until next count 0 transfer, then uses 1.
REQ-035 SHALL test: compare 0 -> pwm low always; compare 5 with period 4 -> pwm high always; write Cmp_sel=CHANNELS -> no change.
REQ-036 SHALL test: Clk_en low 3 cycles at count 2 -> counter holds 2, no transfer; Prd_wr coincident with boundary edge -> old period used one more period.
REQ-037 SHALL test: Rst asserted at count 3 with pending Prd_wr -> next cycle counter 0, period 0, pwm_out 0.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with a shared up or up-down counter.
// Mode, period and compares are double-buffered and take effect when the counter sits at zero.
module pwm_multi_ch #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                Clk_en,
  input  logic                Mode_wr,
  input  logic                Mode_data,
  input  logic                Prd_wr,
  input  logic [WIDTH-1:0]    Prd_data,
  input  logic                Cmp_wr,
  input  logic [SELW-1:0]     Cmp_sel,
  input  logic [WIDTH-1:0]    Cmp_data,
  output logic [WIDTH-1:0]    counter_out,
  output logic                Ctr_0,
  output logic                Ctr_prd,
  output logic [CHANNELS-1:0] pwm_out
);

  // Shadow (software-visible) registers
  logic                 mode_sh_q, mode_sh_d;
  logic [WIDTH-1:0]     prd_sh_q, prd_sh_d;
  logic [WIDTH-1:0]     cmp_sh_q [CHANNELS];
  logic [WIDTH-1:0]     cmp_sh_d [CHANNELS];

  // Active registers used by the counter and comparators
  logic                 mode_q, mode_d;
  logic [WIDTH-1:0]     prd_q, prd_d;
  logic [WIDTH-1:0]     cmp_q [CHANNELS];
  logic [WIDTH-1:0]     cmp_d [CHANNELS];

  // Counter and up-down direction (1 = counting down)
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 dir_dn_q, dir_dn_d;

  logic                 boundary;

  // Shadow writes happen regardless of Clk_en.
  always_comb begin
    mode_sh_d = Mode_wr ? Mode_data : mode_sh_q;
    prd_sh_d  = Prd_wr ? Prd_data : prd_sh_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cmp_sh_d[i] = (Cmp_wr && (32'(Cmp_sel) == i)) ? Cmp_data : cmp_sh_q[i];
    end
  end

  // Active registers load the pre-write shadow values on a boundary edge.
  always_comb begin
    boundary = Clk_en && (cnt_q == '0);
    mode_d   = boundary ? mode_sh_q : mode_q;
    prd_d    = boundary ? prd_sh_q : prd_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cmp_d[i] = boundary ? cmp_sh_q[i] : cmp_q[i];
    end
  end

  // Counter next state, evaluated against the post-transfer active values.
  always_comb begin
    cnt_d    = cnt_q;
    dir_dn_d = dir_dn_q;
    if (Clk_en) begin
      if (boundary) begin
        dir_dn_d = 1'b0;
      end
      if (prd_d == '0) begin
        cnt_d = '0;
      end else if (!mode_d) begin
        cnt_d = (cnt_q >= prd_d) ? '0 : cnt_q + WIDTH'(1);
      end else if (!dir_dn_d) begin
        if (cnt_q >= prd_d) begin
          dir_dn_d = 1'b1;
          cnt_d    = cnt_q - WIDTH'(1);
        end else begin
          cnt_d    = cnt_q + WIDTH'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          dir_dn_d = 1'b0;
          cnt_d    = cnt_q + WIDTH'(1);
        end else begin
          cnt_d    = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      mode_sh_q <= 1'b0;
      prd_sh_q  <= '0;
      mode_q    <= 1'b0;
      prd_q     <= '0;
      cnt_q     <= '0;
      dir_dn_q  <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cmp_sh_q[i] <= '0;
        cmp_q[i]    <= '0;
      end
    end else begin
      mode_sh_q <= mode_sh_d;
      prd_sh_q  <= prd_sh_d;
      mode_q    <= mode_d;
      prd_q     <= prd_d;
      cnt_q     <= cnt_d;
      dir_dn_q  <= dir_dn_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cmp_sh_q[i] <= cmp_sh_d[i];
        cmp_q[i]    <= cmp_d[i];
      end
    end
  end

  always_comb begin
    counter_out = cnt_q;
    Ctr_0       = (cnt_q == '0);
    Ctr_prd     = (cnt_q == prd_q);
    pwm_out     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_out[i] = (cnt_q < cmp_q[i]);
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: expected {counter, pwm, Ctr_0, Ctr_prd} words are
// queued as each cycle's stimulus is driven and compared one cycle later.
module tb_pwm_multi_ch;
  localparam int unsigned W  = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned VW = W + CH + 2;

  logic          clk;
  logic          rst;
  logic          clk_en;
  logic          mode_wr;
  logic          mode_data;
  logic          prd_wr;
  logic [W-1:0]  prd_data;
  logic          cmp_wr;
  logic [SW-1:0] cmp_sel;
  logic [W-1:0]  cmp_data;
  logic [W-1:0]  counter_out;
  logic          ctr_0;
  logic          ctr_prd;
  logic [CH-1:0] pwm_out;

  typedef struct {
    logic [VW-1:0] w;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pwm_multi_ch #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .SELW     (SW)
  ) u_dut (
    .Clock       (clk),
    .Rst         (rst),
    .Clk_en      (clk_en),
    .Mode_wr     (mode_wr),
    .Mode_data   (mode_data),
    .Prd_wr      (prd_wr),
    .Prd_data    (prd_data),
    .Cmp_wr      (cmp_wr),
    .Cmp_sel     (cmp_sel),
    .Cmp_data    (cmp_data),
    .counter_out (counter_out),
    .Ctr_0       (ctr_0),
    .Ctr_prd     (ctr_prd),
    .pwm_out     (pwm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Expected word from a count and the active compares/period the test knows are in force.
  function automatic logic [VW-1:0] ew(int cnt, int c0, int c1, int c2, int prd);
    logic [CH-1:0] p;
    p[0] = (cnt < c0);
    p[1] = (cnt < c1);
    p[2] = (cnt < c2);
    return {W'(cnt), p, (cnt == 0), (cnt == prd)};
  endfunction

  function automatic logic [VW-1:0] obs();
    return {counter_out, pwm_out, ctr_0, ctr_prd};
  endfunction

  function automatic string fmt(logic [VW-1:0] v);
    return $sformatf("cnt=%0d pwm=%b ctr0=%b ctrprd=%b", v[VW-1:CH+2], v[CH+1:2], v[1], v[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst     = 1'b0;
    mode_wr = 1'b0;
    prd_wr  = 1'b0;
    cmp_wr  = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; clk_en = 1'b1;
    mode_wr = 1'b1; mode_data = 1'b1;
    prd_wr = 1'b1; prd_data = 8'd9;
    cmp_wr = 1'b1; cmp_sel = 2'd0; cmp_data = 8'd5;
    sb.push_back('{w: ew(0, 0, 0, 0, 0), name: "reset"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{w: ew(0, 0, 0, 0, 0), name: $sformatf("reset_hold[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
  endtask

  task automatic test_mode0();
    exp_t e;
    clk_en = 1'b0;
    mode_wr = 1'b1; mode_data = 1'b0;
    prd_wr = 1'b1; prd_data = 8'd4;
    cmp_wr = 1'b1; cmp_sel = 2'd0; cmp_data = 8'd2;
    sb.push_back('{w: ew(0, 0, 0, 0, 0), name: "mode0_load"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    clk_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back('{w: ew((k + 1) % 5, 2, 0, 0, 4), name: $sformatf("mode0[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
  endtask

  task automatic test_mode1();
    exp_t e;
    int   seq [6] = '{1, 2, 3, 2, 1, 0};
    clk_en = 1'b0;
    mode_wr = 1'b1; mode_data = 1'b1;
    prd_wr = 1'b1; prd_data = 8'd3;
    cmp_wr = 1'b1; cmp_sel = 2'd1; cmp_data = 8'd2;
    sb.push_back('{w: ew(0, 2, 0, 0, 4), name: "mode1_load"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    clk_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      sb.push_back('{w: ew(seq[k % 6], 2, 2, 0, 3), name: $sformatf("mode1[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
  endtask

  task automatic test_shadow_transfer();
    exp_t e;
    clk_en = 1'b0;
    mode_wr = 1'b1; mode_data = 1'b0;
    prd_wr = 1'b1; prd_data = 8'd4;
    cmp_wr = 1'b1; cmp_sel = 2'd0; cmp_data = 8'd3;
    sb.push_back('{w: ew(0, 2, 2, 0, 3), name: "xfer_load"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    clk_en = 1'b1;
    cmp_sel = 2'd0; cmp_data = 8'd1;
    for (int k = 0; k < 10; k++) begin
      cmp_wr = (k == 2);
      sb.push_back('{w: ew((k + 1) % 5, (k < 5) ? 3 : 1, 2, 0, 4),
                     name: $sformatf("xfer[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    cmp_wr = 1'b0;
  endtask

  task automatic test_cmp_bounds();
    exp_t e;
    logic [SW-1:0] sels [3] = '{2'd0, 2'd1, 2'd3};
    logic [W-1:0]  vals [3] = '{8'd0, 8'd5, 8'd7};
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp_wr = 1'b1; cmp_sel = sels[k]; cmp_data = vals[k];
      sb.push_back('{w: ew(0, 1, 2, 0, 4), name: $sformatf("bounds_load[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    idle_inputs();
    clk_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back('{w: ew((k + 1) % 5, 0, 5, 0, 4), name: $sformatf("bounds[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
  endtask

  task automatic test_clk_en_hold();
    exp_t e;
    int   seq [8] = '{3, 4, 0, 1, 2, 3, 4, 0};
    clk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{w: ew(k + 1, 0, 5, 0, 4), name: $sformatf("hold_run[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    clk_en = 1'b0;
    cmp_sel = 2'd0; cmp_data = 8'd4;
    for (int k = 0; k < 3; k++) begin
      cmp_wr = (k == 0);
      sb.push_back('{w: ew(2, 0, 5, 0, 4), name: $sformatf("hold_at2[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    idle_inputs();
    clk_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sb.push_back('{w: ew(seq[k], (k < 3) ? 0 : 4, 5, 0, 4), name: $sformatf("hold_resume[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    // Parked at zero with Clk_en low: the pending compare must not transfer.
    clk_en = 1'b0;
    cmp_sel = 2'd0; cmp_data = 8'd0;
    for (int k = 0; k < 2; k++) begin
      cmp_wr = (k == 0);
      sb.push_back('{w: ew(0, 4, 5, 0, 4), name: $sformatf("hold_at0[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    cmp_wr = 1'b0;
  endtask

  task automatic test_prd_boundary();
    exp_t e;
    int   cnts [11] = '{1, 2, 3, 4, 0, 1, 2, 0, 1, 2, 0};
    clk_en = 1'b1;
    prd_data = 8'd2;
    for (int k = 0; k < 11; k++) begin
      prd_wr = (k == 0);
      sb.push_back('{w: ew(cnts[k], 0, 5, 0, (k < 5) ? 4 : 2),
                     name: $sformatf("prd_boundary[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    prd_wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    clk_en = 1'b0;
    prd_wr = 1'b1; prd_data = 8'd4;
    sb.push_back('{w: ew(0, 0, 5, 0, 2), name: "rstmid_load"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    clk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{w: ew(k + 1, 0, 5, 0, 4), name: $sformatf("rstmid_run[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
    rst = 1'b1;
    prd_wr = 1'b1; prd_data = 8'd7;
    cmp_wr = 1'b1; cmp_sel = 2'd2; cmp_data = 8'd3;
    mode_wr = 1'b1; mode_data = 1'b1;
    sb.push_back('{w: ew(0, 0, 0, 0, 0), name: "rstmid_reset"});
    tick();
    e = sb.pop_front();
    checks++;
    if (obs() !== e.w) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{w: ew(0, 0, 0, 0, 0), name: $sformatf("rstmid_after[%0d]", k)});
      tick();
      e = sb.pop_front();
      checks++;
      if (obs() !== e.w) begin
        failures++;
        $display("FAIL %s: got %s, expected %s", e.name, fmt(obs()), fmt(e.w));
      end
    end
  endtask

  initial begin
    idle_inputs();
    clk_en    = 1'b0;
    mode_data = 1'b0;
    prd_data  = '0;
    cmp_sel   = '0;
    cmp_data  = '0;
    test_reset();
    test_mode0();
    test_mode1();
    test_shadow_transfer();
    test_cmp_bounds();
    test_clk_en_hold();
    test_prd_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
